// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART transmit feeder.
package uart_pkg;

    localparam int UART_DW         = 8;
    localparam int ACK_TIMEOUT_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// Host write port, status flags and transmitter handshake of the UART feeder.
interface uart_tx_feeder_if #(
    parameter int DEPTH = 16
);
    import uart_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic               wr_en;
    logic [UART_DW-1:0] wr_data;
    logic               full;
    logic               empty;
    logic [AW:0]        count;
    logic               overflow;
    logic               ack_err;
    logic               clr_err;
    logic               tx_xmit;
    logic [UART_DW-1:0] tx_data;
    logic               tx_done_in;

    modport master (
        output wr_en, wr_data, clr_err, tx_done_in,
        input  full, empty, count, overflow, ack_err, tx_xmit, tx_data
    );

    modport slave (
        input  wr_en, wr_data, clr_err, tx_done_in,
        output full, empty, count, overflow, ack_err, tx_xmit, tx_data
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Byte FIFO with AW+1 bit pointers; the extra MSB separates full from empty.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               i_wr_en,
    input  logic [UART_DW-1:0] i_wr_data,
    input  logic               i_pop,
    output logic [UART_DW-1:0] o_rd_data,
    output logic               o_full,
    output logic               o_empty,
    output logic [AW:0]        o_count,
    output logic               o_ovf
);

    localparam logic [AW:0] PTR_ONE = 1;

    logic [UART_DW-1:0] r_mem [DEPTH];
    logic [AW:0]        r_wr_ptr;
    logic [AW:0]        r_rd_ptr;
    logic               w_full;
    logic               w_empty;
    logic               w_push;

    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    // Full is judged before any same-cycle pop, so a write into a full FIFO is always dropped.
    assign w_push  = i_wr_en && !w_full;

    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_ovf     = i_wr_en && w_full;
    assign o_rd_data = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: state registers use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (i_pop && !w_empty)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is not reset; cleared pointers make stale contents unreachable and keep it a plain RAM.
    always_ff @(posedge sys_clk) begin
        if (w_push)
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Drains the byte FIFO into the UART transmitter one frame at a time and tracks errors.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    uart_tx_feeder_if.slave       bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_ONE  = 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

    feeder_state_e      r_state;
    feeder_state_e      w_state_next;
    logic [TW-1:0]      r_tmo_cnt;
    logic [TW-1:0]      w_tmo_next;
    logic               w_pop;
    logic               w_ack_set;
    logic               w_ovf_set;
    logic               w_empty;
    logic [UART_DW-1:0] w_fifo_rd_data;
    logic               r_tx_xmit;
    logic [UART_DW-1:0] r_tx_data;
    logic               r_overflow;
    logic               r_ack_err;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .i_wr_en   (bus.wr_en),
        .i_wr_data (bus.wr_data),
        .i_pop     (w_pop),
        .o_rd_data (w_fifo_rd_data),
        .o_full    (bus.full),
        .o_empty   (w_empty),
        .o_count   (bus.count),
        .o_ovf     (w_ovf_set)
    );

    // NOTE: every output of this block gets a default first, so no branch can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_tmo_next   = r_tmo_cnt;
        w_pop        = 1'b0;
        w_ack_set    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty && bus.tx_done_in) begin
                    w_pop        = 1'b1;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_tmo_next   = '0;
                w_state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!bus.tx_done_in) begin
                    w_state_next = ST_WAIT_DONE;
                end else begin
                    // A start the transmitter never picks up is dropped, not retried.
                    w_tmo_next = r_tmo_cnt + TMO_ONE;
                    if (w_tmo_next == TMO_LAST) begin
                        w_ack_set    = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (bus.tx_done_in)
                    w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state   <= ST_IDLE;
            r_tmo_cnt <= '0;
            r_tx_xmit <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_state   <= w_state_next;
            r_tmo_cnt <= w_tmo_next;
            r_tx_xmit <= (w_state_next == ST_START);
            if (w_pop)
                r_tx_data <= w_fifo_rd_data;
        end
    end

    // Clear wins over a same-cycle set.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_overflow <= 1'b0;
            r_ack_err  <= 1'b0;
        end else if (bus.clr_err) begin
            r_overflow <= 1'b0;
            r_ack_err  <= 1'b0;
        end else begin
            if (w_ovf_set)
                r_overflow <= 1'b1;
            if (w_ack_set)
                r_ack_err <= 1'b1;
        end
    end

    assign bus.empty    = w_empty;
    assign bus.overflow = r_overflow;
    assign bus.ack_err  = r_ack_err;
    assign bus.tx_xmit  = r_tx_xmit;
    assign bus.tx_data  = r_tx_data;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a simple transmitter model and a start-pulse monitor.
module tb_uart_tx_feeder;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int TMO   = 8;
    localparam int FRAME = 5;

    logic sys_clk = 1'b0;
    logic sys_rst;
    logic man_done;
    logic m_use;
    logic m_done;
    logic m_pend;
    int   m_left;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [7:0] q_sent[$];
    int         n_bad_xmit = 0;
    int         n_unstable = 0;
    int         n_double   = 0;
    logic       have_prev;
    logic       seen_low;
    logic [7:0] last_data;

    uart_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_feeder #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    assign bus.tx_done_in = m_use ? m_done : man_done;

    // Transmitter model: goes busy the cycle after a start, stays busy FRAME cycles.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            m_done = 1'b1;
            m_pend = 1'b0;
            m_left = 0;
        end else if (m_pend) begin
            m_pend = 1'b0;
            m_done = 1'b0;
            m_left = FRAME;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0)
                m_done = 1'b1;
        end else if (bus.tx_xmit) begin
            m_pend = 1'b1;
        end
    end

    // Records every start pulse and flags handshake rule violations.
    always @(negedge sys_clk) begin
        if (sys_rst) begin
            have_prev = 1'b0;
            seen_low  = 1'b0;
            last_data = 8'h00;
        end else begin
            if (!bus.tx_done_in)
                seen_low = 1'b1;
            if (bus.tx_xmit) begin
                q_sent.push_back(bus.tx_data);
                if (!bus.tx_done_in)
                    n_bad_xmit++;
                if (have_prev && !seen_low)
                    n_double++;
                have_prev = 1'b1;
                seen_low  = 1'b0;
                last_data = bus.tx_data;
            end else if (bus.tx_data !== last_data) begin
                n_unstable++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic wait_sent(input int target, input int budget);
        int k = 0;
        while (q_sent.size() < target && k < budget) begin
            tick(1);
            k++;
        end
        tick(20);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int k;

        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.clr_err = 1'b0;
        man_done    = 1'b0;
        m_use       = 1'b0;
        sys_rst     = 1'b0;
        #1 sys_rst  = 1'b1;
        #2;

        // Reset state
        check("rst_xmit",    32'(bus.tx_xmit),  0);
        check("rst_data",    32'(bus.tx_data),  0);
        check("rst_full",    32'(bus.full),     0);
        check("rst_empty",   32'(bus.empty),    1);
        check("rst_count",   32'(bus.count),    0);
        check("rst_ovf",     32'(bus.overflow), 0);
        check("rst_ack_err", 32'(bus.ack_err),  0);

        tick(2);
        sys_rst  = 1'b0;
        man_done = 1'b0;
        tick(1);
        man_done = 1'b1;

        // Single byte: write at cycle 0, start at cycle 2
        base        = q_sent.size();
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hA5;
        tick(1);
        bus.wr_en = 1'b0;
        check("sb_c1_empty", 32'(bus.empty),   0);
        check("sb_c1_count", 32'(bus.count),   1);
        check("sb_c1_xmit",  32'(bus.tx_xmit), 0);
        tick(1);
        check("sb_c2_xmit",  32'(bus.tx_xmit), 1);
        check("sb_c2_data",  32'(bus.tx_data), 32'h A5);
        check("sb_c2_count", 32'(bus.count),   0);
        tick(1);
        check("sb_c3_xmit",  32'(bus.tx_xmit), 0);
        tick(1);
        man_done = 1'b0;
        tick(96);
        man_done = 1'b1;
        tick(3);
        check("sb_pulses",  q_sent.size(), base + 1);
        check("sb_byte",    32'(q_sent[base]), 32'h A5);
        check("sb_count",   32'(bus.count),   0);
        check("sb_ack_err", 32'(bus.ack_err), 0);

        // Back-to-back writes drained through the transmitter model
        m_use       = 1'b1;
        base        = q_sent.size();
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h11;
        tick(1);
        bus.wr_data = 8'h22;
        tick(1);
        bus.wr_data = 8'h33;
        tick(1);
        bus.wr_en = 1'b0;
        wait_sent(base + 3, 300);
        check("b2b_pulses", q_sent.size(), base + 3);
        check("b2b_byte0",  32'(q_sent[base]),     32'h 11);
        check("b2b_byte1",  32'(q_sent[base + 1]), 32'h 22);
        check("b2b_byte2",  32'(q_sent[base + 2]), 32'h 33);

        // Fill to DEPTH with the transmitter busy, then overflow
        m_use    = 1'b0;
        man_done = 1'b0;
        tick(1);
        base = q_sent.size();
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(i);
            tick(1);
        end
        bus.wr_en = 1'b0;
        check("full_flag",  32'(bus.full),     1);
        check("full_count", 32'(bus.count),    DEPTH);
        check("full_ovf0",  32'(bus.overflow), 0);
        check("full_noxmt", 32'(bus.tx_xmit),  0);

        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h10;
        bus.clr_err = 1'b1;
        tick(1);
        check("ovf_clr_wins", 32'(bus.overflow), 0);
        check("ovf_cnt_hold", 32'(bus.count),    DEPTH);

        bus.clr_err = 1'b0;
        man_done    = 1'b1;
        tick(1);
        check("ovf_pop_cnt",  32'(bus.count),    DEPTH - 1);
        check("ovf_pop_full", 32'(bus.full),     0);
        check("ovf_set",      32'(bus.overflow), 1);
        check("ovf_xmit",     32'(bus.tx_xmit),  1);
        check("ovf_data",     32'(bus.tx_data),  0);

        bus.wr_en   = 1'b0;
        bus.clr_err = 1'b1;
        m_use       = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
        check("ovf_cleared", 32'(bus.overflow), 0);
        wait_sent(base + DEPTH, 1000);
        check("fill_pulses", q_sent.size(), base + DEPTH);
        for (int i = 0; i < DEPTH; i++)
            check($sformatf("fill_byte%0d", i), 32'(q_sent[base + i]), i);
        check("fill_empty", 32'(bus.empty), 1);

        // Wrap-around: 40 bytes with random gaps
        base = q_sent.size();
        for (int i = 0; i < 40; i++) begin
            k = 0;
            while (bus.full && k < 200) begin
                tick(1);
                k++;
            end
            bus.wr_en   = 1'b1;
            bus.wr_data = 8'(i);
            tick(1);
            bus.wr_en = 1'b0;
            tick(int'($urandom_range(0, 3)));
        end
        wait_sent(base + 40, 3000);
        check("wrap_pulses", q_sent.size(), base + 40);
        for (int i = 0; i < 40; i++)
            check($sformatf("wrap_byte%0d", i), 32'(q_sent[base + i]), i);
        check("wrap_ovf", 32'(bus.overflow), 0);

        // Reset in WAIT_DONE with three bytes queued
        base        = q_sent.size();
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h71;
        tick(1);
        bus.wr_data = 8'h72;
        tick(1);
        bus.wr_data = 8'h73;
        tick(1);
        bus.wr_data = 8'h74;
        tick(1);
        bus.wr_en = 1'b0;
        tick(1);
        check("mid_count",  32'(bus.count), 3);
        check("mid_pulses", q_sent.size(), base + 1);
        sys_rst = 1'b1;
        #1;
        check("mid_rst_xmit",  32'(bus.tx_xmit), 0);
        check("mid_rst_empty", 32'(bus.empty),   1);
        check("mid_rst_count", 32'(bus.count),   0);
        check("mid_rst_data",  32'(bus.tx_data), 0);
        m_use    = 1'b0;
        man_done = 1'b0;
        tick(2);
        sys_rst = 1'b0;
        tick(1);
        man_done = 1'b1;
        tick(20);
        check("mid_no_start", q_sent.size(), base + 1);
        check("mid_empty",    32'(bus.empty), 1);

        // Ack timeout: transmitter never goes busy
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h5A;
        tick(1);
        bus.wr_en = 1'b0;
        tick(1);
        check("tmo_xmit", 32'(bus.tx_xmit), 1);
        check("tmo_data", 32'(bus.tx_data), 32'h 5A);
        tick(TMO - 1);
        check("tmo_early", 32'(bus.ack_err), 0);
        tick(1);
        check("tmo_set",  32'(bus.ack_err), 1);
        tick(30);
        check("tmo_no_retry", q_sent.size(), base + 2);
        check("tmo_byte",     32'(q_sent[base + 1]), 32'h 5A);
        check("tmo_empty",    32'(bus.empty),   1);
        check("tmo_sticky",   32'(bus.ack_err), 1);
        bus.clr_err = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
        check("tmo_cleared", 32'(bus.ack_err), 0);

        // Handshake rules over the whole run
        check("xmit_while_busy", n_bad_xmit, 0);
        check("data_unstable",   n_unstable, 0);
        check("start_no_frame",  n_double,   0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
